operand_capture: RTL and testbench
==================================

// Module: operand_capture
// PURPOSE
//   Parametrised, clocked operand loader for the crypto datapath. Debounces the raw board push-button,
//   snapshots N_CH operand lanes (default: plaintext, key, IV) on each debounced press, zeroes disabled
//   lanes, and holds the snapshot behind a valid/ready handshake to the AES/SHAKE core.
//   Lane k of every flat bus occupies bits [k*DATA_W +: DATA_W]; lane 0 = plaintext, 1 = key, 2 = IV.
// PARAMETERS
//   DATA_W           128  width of one operand lane in bits
//   N_CH             3    number of operand lanes (>=1)
//   DEBOUNCE_CYCLES  16   cycles the synchronised button must hold a new level before it is accepted (>=1)
//   CNT_W (local)    $clog2(DEBOUNCE_CYCLES+1)  width of the debounce counter
// PORTS
//   i_clk            in   1             system clock, all logic rising-edge
//   i_rst            in   1             synchronous, active-high reset
//   i_press          in   1             raw, asynchronous push-button level
//   i_data           in   N_CH*DATA_W   live operand lanes, flat
//   i_ch_en          in   N_CH          per-lane enable; a disabled lane captures as all-zero
//   i_ready          in   1             core accepts o_data this cycle when o_valid=1
//   o_data           out  N_CH*DATA_W   captured operand lanes, flat
//   o_valid          out  1             o_data holds an unconsumed snapshot
//   o_busy           out  1             state != IDLE
//   o_overrun        out  1             sticky: a debounced press arrived while state = HOLD
//   o_capture_cnt    out  8             number of snapshots taken, wraps 255->0
// BEHAVIOUR
//   Reset (i_rst=1 at an edge): state=IDLE, sync FFs=0, press_db=0, debounce cnt=0, o_data=0,
//     o_valid=0, o_busy=0, o_overrun=0, o_capture_cnt=0. Reset mid-HOLD drops the pending snapshot;
//     no handshake completes in the reset cycle.
//   Synchroniser: 2-FF chain i_press -> s1 -> s2.
//   Debounce: if s2==press_db, cnt<=0. Otherwise, if cnt==DEBOUNCE_CYCLES-1, press_db<=s2 and cnt<=0;
//     else cnt<=cnt+1. Any bounce back to the press_db level restarts the count from zero.
//   Rise = press_db 0->1, registered as a one-cycle pulse in the cycle after press_db changes.
//   Latency: i_press high and stable from edge E -> press_db high after edge E+1+DEBOUNCE_CYCLES
//     -> o_valid=1 with new o_data after edge E+2+DEBOUNCE_CYCLES.
//   FSM:
//     IDLE:     on rise: o_data lane k <= i_ch_en[k] ? i_data lane k : 0; o_valid<=1;
//               o_capture_cnt<=+1; ->HOLD. Otherwise stay.
//     HOLD:     o_data and o_valid stable. On o_valid&i_ready: o_valid<=0; ->WAIT_REL if press_db=1,
//               else ->IDLE. A rise while in HOLD sets o_overrun and is otherwise discarded
//               (no recapture, no count). A rise coincident with the transfer also sets o_overrun.
//     WAIT_REL: ->IDLE when press_db=0. A rise cannot occur here; a press needs release first.
//   o_data keeps the last snapshot after the transfer; it changes only on a capture or a reset.
//   Changes on i_data/i_ch_en outside the capture cycle never affect o_data.
//   o_busy = (state != IDLE), registered with state.
//   i_ready while o_valid=0 has no effect. o_overrun clears only on reset.
//   o_capture_cnt wraps 255->0 with no flag.
// TESTING
//   1 Reset: hold i_rst 2 cycles with i_press=1 -> every output 0, state IDLE; after release, no capture
//     until the debounce completes.
//   2 Clean press, DEBOUNCE_CYCLES=16, i_ch_en=3'b111, lanes=0x00112233..,0x2b7e1516..,0x0f0e0d0c.. ->
//     o_valid rises exactly 18 edges after the first sampled high; o_data = lanes; o_capture_cnt=1.
//   3 Bounce: toggle i_press every 5 cycles for 60 cycles, then hold high -> exactly one capture, 18 edges
//     after the final stable edge.
//   4 Handshake: hold i_ready=0 for 10 cycles while i_data changes -> o_data/o_valid stable; i_ready=1 ->
//     o_valid=0 next edge; state WAIT_REL until release, then IDLE.
//   5 Lane mask: i_ch_en=3'b101 -> lane 1 of o_data = 0, lanes 0 and 2 = inputs.
//   6 Overrun/wrap: release and re-press while HOLD -> o_overrun=1, count unchanged; 256 full press/ack
//     cycles -> o_capture_cnt returns to 0.

Source files
------------

// File: rtl/operand_capture.sv
// Operand loader for the crypto datapath: debounces the push-button, snapshots the operand lanes
// on each debounced press and holds them behind a valid/ready handshake.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no pending snapshot; a debounced rise captures the lanes
//   HOLD     | snapshot valid, waiting for the core to accept it
//   WAIT_REL | snapshot consumed while the button is still held down
module operand_capture #(
  parameter int DATA_W          = 128,
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_press,
  input  logic [N_CH*DATA_W-1:0] i_data,
  input  logic [N_CH-1:0]        i_ch_en,
  input  logic                   i_ready,
  output logic [N_CH*DATA_W-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic [7:0]             o_capture_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t                  state;
  logic                    s1;
  logic                    s2;
  logic                    press_db;
  logic [CNT_W-1:0]        cnt;
  logic                    rise;
  logic [N_CH*DATA_W-1:0]  cap_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_press;
      s2 <= s1;
    end
  end

  // rise is set on the same edge press_db goes high, so it is visible the cycle after the change
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      press_db <= 1'b0;
      cnt      <= '0;
      rise     <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (s2 == press_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        press_db <= s2;
        cnt      <= '0;
        rise     <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_ch_en[k]) cap_data[k*DATA_W +: DATA_W] = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
      o_capture_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            o_data        <= cap_data;
            o_valid       <= 1'b1;
            o_capture_cnt <= o_capture_cnt + 8'd1;
            state         <= HOLD;
            o_busy        <= 1'b1;
          end
        end
        HOLD: begin
          if (rise) o_overrun <= 1'b1;
          if (o_valid && i_ready) begin
            o_valid <= 1'b0;
            if (press_db) begin
              state  <= WAIT_REL;
              o_busy <= 1'b1;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        WAIT_REL: begin
          if (!press_db) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture with default parameters (128-bit lanes, 3 lanes, 16-cycle debounce).
module tb_operand_capture;

  localparam int W = 384;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_press;
  logic [W-1:0]   i_data;
  logic [2:0]     i_ch_en;
  logic           i_ready;
  logic [W-1:0]   o_data;
  logic           o_valid;
  logic           o_busy;
  logic           o_overrun;
  logic [7:0]     o_capture_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] L0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] L1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] L2 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic [W-1:0] data3;

  operand_capture dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_press(i_press), .i_data(i_data), .i_ch_en(i_ch_en),
    .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_capture_cnt(o_capture_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    data1 = {L2, L1, L0};
    data2 = {128'hdeadbeef_00000000_11111111_22222222, 128'h0123456789abcdef0123456789abcdef,
             128'hcafef00d_55555555_aaaaaaaa_12345678};
    data3 = {128'h33333333_44444444_55555555_66666666, 128'hffffffff_eeeeeeee_dddddddd_cccccccc,
             128'h77777777_88888888_99999999_00000001};

    // reset with the button already held
    i_rst = 1'b1; i_press = 1'b1; i_data = data1; i_ch_en = 3'b111; i_ready = 1'b0;
    tick(2);
    chk("rst_data", o_data, '0);
    chk("rst_valid", W'(o_valid), '0);
    chk("rst_busy", W'(o_busy), '0);
    chk("rst_overrun", W'(o_overrun), '0);
    chk("rst_cnt", W'(o_capture_cnt), '0);

    // first sampled-high edge is the next one; capture appears 18 edges after it
    i_rst = 1'b0;
    tick(18);
    chk("clean_early_valid", W'(o_valid), '0);
    chk("clean_early_cnt", W'(o_capture_cnt), '0);
    tick(1);
    chk("clean_valid", W'(o_valid), W'(1));
    chk("clean_data", o_data, data1);
    chk("clean_cnt", W'(o_capture_cnt), W'(1));
    chk("clean_busy", W'(o_busy), W'(1));

    // stall: live inputs change, snapshot must not
    for (int i = 0; i < 10; i++) begin
      i_data = data1 ^ W'(i * 7 + 1);
      i_ch_en = 3'(i);
      tick(1);
    end
    chk("stall_data", o_data, data1);
    chk("stall_valid", W'(o_valid), W'(1));
    i_ch_en = 3'b111;
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    chk("ack_valid", W'(o_valid), '0);
    chk("waitrel_busy", W'(o_busy), W'(1));
    chk("ack_data_kept", o_data, data1);
    tick(5);
    chk("waitrel_hold", W'(o_busy), W'(1));
    i_press = 1'b0;
    tick(20);
    chk("release_idle", W'(o_busy), '0);

    // bounce: 12 segments of 5 cycles, then stable high
    i_data = data2;
    for (int s = 0; s < 12; s++) begin
      i_press = (s % 2 == 0);
      tick(5);
    end
    chk("bounce_no_capture", W'(o_valid), '0);
    chk("bounce_cnt_hold", W'(o_capture_cnt), W'(1));
    i_press = 1'b1;
    tick(18);
    chk("bounce_early_valid", W'(o_valid), '0);
    tick(1);
    chk("bounce_valid", W'(o_valid), W'(1));
    chk("bounce_data", o_data, data2);
    chk("bounce_cnt", W'(o_capture_cnt), W'(2));
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    i_press = 1'b0;
    tick(20);
    chk("bounce_idle", W'(o_busy), '0);

    // lane mask 101
    i_data = data3;
    i_ch_en = 3'b101;
    i_press = 1'b1;
    tick(19);
    chk("mask_data", o_data, {data3[383:256], 128'h0, data3[127:0]});
    chk("mask_cnt", W'(o_capture_cnt), W'(3));

    // release and re-press while the snapshot is still pending
    i_ch_en = 3'b111;
    i_press = 1'b0;
    tick(20);
    chk("hold_after_release", W'(o_valid), W'(1));
    chk("no_overrun_yet", W'(o_overrun), '0);
    i_press = 1'b1;
    tick(20);
    chk("overrun_set", W'(o_overrun), W'(1));
    chk("overrun_cnt", W'(o_capture_cnt), W'(3));
    chk("overrun_data", o_data, {data3[383:256], 128'h0, data3[127:0]});
    i_ready = 1'b1;
    tick(1);
    chk("overrun_ack", W'(o_valid), '0);
    i_press = 1'b0;
    tick(21);

    // count 3 -> 255 -> 0 with the core always ready
    for (int n = 4; n <= 256; n++) begin
      i_press = 1'b1;
      tick(19);
      chk("wrap_cnt", W'(o_capture_cnt), W'(n % 256));
      i_press = 1'b0;
      tick(21);
    end
    chk("wrap_overrun_sticky", W'(o_overrun), W'(1));

    // reset while a snapshot is pending, with i_ready high
    i_press = 1'b1;
    tick(19);
    chk("pre_rst_valid", W'(o_valid), W'(1));
    i_rst = 1'b1;
    tick(1);
    chk("midhold_rst_valid", W'(o_valid), '0);
    chk("midhold_rst_data", o_data, '0);
    chk("midhold_rst_overrun", W'(o_overrun), '0);
    chk("midhold_rst_busy", W'(o_busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
